// File: rtl/sdram_line_client.sv
// sdram_line_client: one-line write-back buffer between a 32-bit CPU port
// and the SDRAM controller's block request/ack interface.
//
// Optional flush support: define SDRAM_LINE_CLIENT_FLUSH_EN to add the
// iflush input and the oflush_done pulse output.
//
// Ports:
//   iclk, ireset            clock, synchronous active-high reset
//   icpu_*                  CPU level request, held until ocpu_ready
//   ocpu_rdata, ocpu_ready  load data and one-cycle completion pulse
//   owrite_* / iwrite_ack   line writeback request to the controller
//   oread_* / iread_*       line fill request to the controller
//   iin_use                 controller busy; new requests wait for it
//   iflush, oflush_done     (flush build only) write back and invalidate
module sdram_line_client #(
  parameter int  BLOCK_BITS = 128,
  localparam int OFS        = $clog2(BLOCK_BITS / 8)
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic                  icpu_req,
  input  logic                  icpu_we,
  input  logic [21+OFS:0]       icpu_addr,
  input  logic [3:0]            icpu_be,
  input  logic [31:0]           icpu_wdata,
  output logic [31:0]           ocpu_rdata,
  output logic                  ocpu_ready,
  output logic                  owrite_req,
  output logic [21:0]           owrite_address,
  output logic [BLOCK_BITS-1:0] owrite_data,
  input  logic                  iwrite_ack,
  output logic                  oread_req,
  output logic [21:0]           oread_address,
  input  logic [BLOCK_BITS-1:0] iread_data,
  input  logic                  iread_ack,
`ifdef SDRAM_LINE_CLIENT_FLUSH_EN
  input  logic                  iflush,
  output logic                  oflush_done,
`endif
  input  logic                  iin_use
);

  localparam int WSEL = OFS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  dirty_q, dirty_d;
  logic [21:0]           tag_q, tag_d;
  logic [BLOCK_BITS-1:0] line_q, line_d;
  logic                  we_q, we_d;
  logic [21:0]           rtag_q, rtag_d;
  logic [WSEL-1:0]       word_q, word_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_hold_q, wr_hold_d;
  logic                  rd_hold_q, rd_hold_d;
  logic                  flush_q;
  logic                  flush_go;
  logic                  hit;
  logic [1:0]            unused_addr;

  assign unused_addr = icpu_addr[1:0];
  assign hit = valid_q && (tag_q == rtag_q);

`ifdef SDRAM_LINE_CLIENT_FLUSH_EN
  logic flush_d;
  assign flush_go = iflush;

  always_ff @(posedge iclk) begin
    if (ireset) flush_q <= 1'b0;
    else        flush_q <= flush_d;
  end
`else
  assign flush_go = 1'b0;
  assign flush_q  = 1'b0;
`endif

  function automatic logic [BLOCK_BITS-1:0] merge(
    input logic [BLOCK_BITS-1:0] l,
    input logic [WSEL-1:0]       w,
    input logic [3:0]            be,
    input logic [31:0]           d
  );
    logic [BLOCK_BITS-1:0] r;
    r = l;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[32*int'(w)+8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // state register
  always_ff @(posedge iclk) begin
    if (ireset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_go || icpu_req) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!flush_q && hit)        state_d = S_RESP;
        else if (valid_q && dirty_q) state_d = S_WB;
        else if (flush_q)           state_d = S_RESP;
        else                        state_d = S_FILL;
      end
      S_WB: begin
        if (iwrite_ack) state_d = flush_q ? S_RESP : S_FILL;
      end
      S_FILL: begin
        if (iread_ack) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs; a request rises only when the controller is idle, then
  // stays up regardless of iin_use until its ack edge
  always_comb begin
    ocpu_ready     = (state_q == S_RESP) && !flush_q;
    ocpu_rdata     = ocpu_ready ? line_q[32*int'(word_q) +: 32] : 32'h0;
    owrite_req     = (state_q == S_WB) && (!iin_use || wr_hold_q);
    oread_req      = (state_q == S_FILL) && (!iin_use || rd_hold_q);
    owrite_address = tag_q;
    owrite_data    = line_q;
    oread_address  = rtag_q;
`ifdef SDRAM_LINE_CLIENT_FLUSH_EN
    oflush_done    = (state_q == S_RESP) && flush_q;
`endif
  end

  // line and request datapath
  always_comb begin
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    line_d    = line_q;
    we_d      = we_q;
    rtag_d    = rtag_q;
    word_d    = word_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wr_hold_d = owrite_req && !iwrite_ack;
    rd_hold_d = oread_req && !iread_ack;
`ifdef SDRAM_LINE_CLIENT_FLUSH_EN
    flush_d   = flush_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (flush_go) begin
`ifdef SDRAM_LINE_CLIENT_FLUSH_EN
          flush_d = 1'b1;
`endif
        end else if (icpu_req) begin
          we_d    = icpu_we;
          rtag_d  = icpu_addr[21+OFS:OFS];
          word_d  = icpu_addr[OFS-1:2];
          be_d    = icpu_be;
          wdata_d = icpu_wdata;
`ifdef SDRAM_LINE_CLIENT_FLUSH_EN
          flush_d = 1'b0;
`endif
        end
      end
      S_CHECK: begin
        if (flush_q) begin
          if (!(valid_q && dirty_q)) valid_d = 1'b0;
        end else if (hit && we_q) begin
          line_d  = merge(line_q, word_q, be_q, wdata_q);
          dirty_d = 1'b1;
        end
      end
      S_WB: begin
        if (iwrite_ack) begin
          dirty_d = 1'b0;
          if (flush_q) valid_d = 1'b0;
        end
      end
      S_FILL: begin
        if (iread_ack) begin
          // write-allocate: the store lands in the same edge as the fill
          line_d  = we_q ? merge(iread_data, word_q, be_q, wdata_q)
                         : iread_data;
          tag_d   = rtag_q;
          valid_d = 1'b1;
          dirty_d = we_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      valid_q   <= 1'b0;
      dirty_q   <= 1'b0;
      tag_q     <= '0;
      line_q    <= '0;
      we_q      <= 1'b0;
      rtag_q    <= '0;
      word_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wr_hold_q <= 1'b0;
      rd_hold_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      tag_q     <= tag_d;
      line_q    <= line_d;
      we_q      <= we_d;
      rtag_q    <= rtag_d;
      word_q    <= word_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wr_hold_q <= wr_hold_d;
      rd_hold_q <= rd_hold_d;
    end
  end

endmodule
